particle_filter_v3: RTL and testbench
=====================================

# particle_filter_v3

Parametrised successor of the per-sample particle filter in the ACC datapath. The block subtracts haze from laser data and thresholds the result for the current sample. It also compares a cached sample taken a programmable light-spot spacing earlier, combines the two verdicts by mode, and tracks a saturating run-length of consecutive hits. It sits between the ACC laser stream and the downstream particle-marking logic.

## Interface
- TCQ, 0.1: simulation clock-to-Q delay.
- DATA_WIDTH, 16: laser/haze/threshold width.
- SPACING_AW, 11: cache address width; depth is 2^SPACING_AW samples.
- HIT_CNT_W, 8: hit run-length counter width.

- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- laser_acc_flag_i  in  1  acceleration-zone flag, qualified by laser_vld_i.
- laser_vld_i  in  1  sample strobe.
- laser_data_i  in  DATA_WIDTH  raw laser sample.
- laser_haze_data_i  in  DATA_WIDTH  haze baseline.
- light_spot_spacing_i  in  SPACING_AW  cache distance in samples; 0 disables the cache path.
- filter_mode_i  in  2  0 curr only, 1 cache only, 2 AND, 3 OR.
- filter_curr_thre_i  in  DATA_WIDTH  current-path threshold.
- filter_cache_thre_i  in  DATA_WIDTH  cache-path threshold.
- lp_filter_cache_thre_i  in  DATA_WIDTH  cache threshold used when the cached sample's acc flag is 1.
- filter_acc_flag_o  out  1  aligned acc flag.
- filter_vld_o  out  1  output strobe.
- filter_data_o  out  DATA_WIDTH  aligned raw data.
- filter_haze_data_o  out  DATA_WIDTH  aligned haze input.
- filter_haze_hub_o  out  DATA_WIDTH  clamped current difference.
- filter_curr_result_o  out  1  current verdict.
- filter_cache_result_o  out  1  cache verdict.
- filter_result_o  out  1  mode-combined verdict.
- filter_hit_cnt_o  out  HIT_CNT_W  consecutive filter_result_o hits, saturating.
- cache_ready_o  out  1  cache path has valid history for the current spacing.

## Operation
- Difference: computed at DATA_WIDTH+1 bits as data − haze. If the sign bit is set the result is 0; otherwise it is the low DATA_WIDTH bits. The same rule applies to both paths.
- Compare: the verdict is diff > threshold, strictly greater. Verdicts are evaluated only for valid samples.
- Cache: each valid sample writes {acc_flag, haze, data} at wr_ptr, then wr_ptr increments modulo 2^SPACING_AW. The read address is wr_ptr − spacing, using the spacing sampled with the same strobe.
- Fill: fill_cnt counts written samples and saturates at 2^SPACING_AW − 1. cache_ready holds when spacing ≠ 0 and fill_cnt ≥ spacing. When cache_ready is 0, cache_result is forced to 0.
- Cached threshold: if the cached acc flag is 1, use lp_filter_cache_thre_i; otherwise use filter_cache_thre_i.
- Combine: filter_result is selected per filter_mode_i, sampled with the strobe.
- Hit counter: on each output strobe, it increments on result = 1, saturating at all-ones, and clears to 0 on result = 0. It holds between strobes.
- Reset: wr_ptr, fill_cnt, pipeline valids and all outputs go to 0. In-flight samples are dropped. RAM contents are not cleared; fill_cnt gating makes stale data unreachable.

## Timing
- Latency: a sample strobed at cycle T produces all outputs at T+3 with a 1-cycle filter_vld_o. Every output field is aligned to that strobe.
- Stage 1 (T+1): registered RAM read; registered current difference.
- Stage 2 (T+2): registered cached difference and both comparisons.
- Stage 3 (T+3): combine, hit count and output registers.
- Throughput: back-to-back strobes are accepted every cycle.
- Non-strobe cycles: verdict and data outputs hold their last value; filter_vld_o = 0.
- Wrap-around: spacing ≤ 2^SPACING_AW − 1 always addresses written history once fill_cnt saturates.
- Spacing change mid-stream: takes effect at the next strobe; no flush.
- rst_i together with laser_vld_i: reset wins and the sample is discarded.

## Structure
- Package particle_filter_pkg holds:
  - mode encodings MODE_CURR/MODE_CACHE/MODE_AND/MODE_OR;
  - PF_LATENCY = 3;
  - the cache word width function 2*DATA_WIDTH+1.
- Sub-module filter_cache_ram: simple dual-port RAM with one write port, a 1-cycle registered read, depth 2^SPACING_AW, and parametrised width.

## Test plan
- Reset: assert rst_i for 2 cycles → every output is 0 and cache_ready_o = 0. Repeat mid-stream → no filter_vld_o for samples in flight.
- Current path, mode 0, thre 700:
  - data 1000, haze 200 → at T+3, hub 800 and curr = result = 1.
  - data 100, haze 300 → hub 0 and result 0.
- Cache path, mode 1, spacing 4, samples i = 0..9 with data 100·i, haze 0, cache thre 250:
  - cache_result is 0 for the first 4 samples.
  - sample 7 then compares data 300 → 1.
  - sample 6 compares data 200 → 0.
- LP threshold: cached sample with acc = 1 and diff 500, cache thre 600, lp thre 400 → cache_result 1. Same sample with acc = 0 → 0.
- Modes and counter, HIT_CNT_W = 2:
  - curr = 1, cache = 0 → AND gives 0 and OR gives 1.
  - 5 OR hits → count 3 (saturated).
  - One miss → count 0.
- Wrap: SPACING_AW = 3, spacing 7, 20 back-to-back samples → each cache compare uses sample n−7, and cache_ready_o rises at the 8th sample.

Source files
------------

// File: rtl/particle_filter_pkg.sv
// Shared types and constants for the particle filter datapath.
// Mode encodings, pipeline depth and cache word sizing.
package particle_filter_pkg;

  typedef enum logic [1:0] {
    MODE_CURR  = 2'd0,
    MODE_CACHE = 2'd1,
    MODE_AND   = 2'd2,
    MODE_OR    = 2'd3
  } pf_mode_e;

  localparam int PF_LATENCY = 3;

  function automatic int cache_word_w(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/particle_filter_v3_if.sv
// Laser sample in / filter verdict out bundle.
// The filter itself is the slave; the laser source is the master.
interface particle_filter_v3_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SPACING_AW = 11,
  parameter int HIT_CNT_W  = 8
);

  logic                  laser_acc_flag_i;
  logic                  laser_vld_i;
  logic [DATA_WIDTH-1:0] laser_data_i;
  logic [DATA_WIDTH-1:0] laser_haze_data_i;
  logic [SPACING_AW-1:0] light_spot_spacing_i;
  logic [1:0]            filter_mode_i;
  logic [DATA_WIDTH-1:0] filter_curr_thre_i;
  logic [DATA_WIDTH-1:0] filter_cache_thre_i;
  logic [DATA_WIDTH-1:0] lp_filter_cache_thre_i;

  logic                  filter_acc_flag_o;
  logic                  filter_vld_o;
  logic [DATA_WIDTH-1:0] filter_data_o;
  logic [DATA_WIDTH-1:0] filter_haze_data_o;
  logic [DATA_WIDTH-1:0] filter_haze_hub_o;
  logic                  filter_curr_result_o;
  logic                  filter_cache_result_o;
  logic                  filter_result_o;
  logic [HIT_CNT_W-1:0]  filter_hit_cnt_o;
  logic                  cache_ready_o;

  modport master (
    output laser_acc_flag_i, laser_vld_i,
    output laser_data_i, laser_haze_data_i,
    output light_spot_spacing_i, filter_mode_i,
    output filter_curr_thre_i, filter_cache_thre_i,
    output lp_filter_cache_thre_i,
    input  filter_acc_flag_o, filter_vld_o,
    input  filter_data_o, filter_haze_data_o,
    input  filter_haze_hub_o, filter_curr_result_o,
    input  filter_cache_result_o, filter_result_o,
    input  filter_hit_cnt_o, cache_ready_o
  );

  modport slave (
    input  laser_acc_flag_i, laser_vld_i,
    input  laser_data_i, laser_haze_data_i,
    input  light_spot_spacing_i, filter_mode_i,
    input  filter_curr_thre_i, filter_cache_thre_i,
    input  lp_filter_cache_thre_i,
    output filter_acc_flag_o, filter_vld_o,
    output filter_data_o, filter_haze_data_o,
    output filter_haze_hub_o, filter_curr_result_o,
    output filter_cache_result_o, filter_result_o,
    output filter_hit_cnt_o, cache_ready_o
  );

endinterface

// File: rtl/filter_cache_ram.sv
// Simple dual-port sample history RAM.
// One write port, registered read port, no reset on contents.
module filter_cache_ram #(
  parameter int AW = 11,
  parameter int W  = 33
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/particle_filter_v3.sv
// Haze-subtracting particle filter with spaced-history compare.
// Three-stage pipeline: read/diff, compare, combine/count.
module particle_filter_v3
  import particle_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SPACING_AW = 11,
  parameter int HIT_CNT_W  = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  particle_filter_v3_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = SPACING_AW;
  localparam int HW = HIT_CNT_W;
  localparam int CW = cache_word_w(DW);

  typedef logic [DW-1:0] word_t;

  function automatic word_t clamp_diff(
    input word_t a,
    input word_t b
  );
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DW] ? '0 : d[DW-1:0];
  endfunction

  logic          in_vld;
  logic          in_ready;
  logic [AW-1:0] spacing;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fill_cnt;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] wr_word;
  logic [CW-1:0] rd_word;

  // a sample coinciding with reset is discarded
  assign in_vld   = bus.laser_vld_i & ~rst_i;
  assign spacing  = bus.light_spot_spacing_i;
  assign rd_addr  = wr_ptr - spacing;
  assign in_ready = (spacing != '0) && (fill_cnt >= spacing);
  assign wr_word  = {bus.laser_acc_flag_i,
                     bus.laser_haze_data_i,
                     bus.laser_data_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (in_vld) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (fill_cnt != '1) fill_cnt <= fill_cnt + AW'(1);
    end
  end

  filter_cache_ram #(
    .AW (AW),
    .W  (CW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (in_vld),
    .waddr_i (wr_ptr),
    .wdata_i (wr_word),
    .re_i    (in_vld),
    .raddr_i (rd_addr),
    .rdata_o (rd_word)
  );

  logic     s1_vld;
  logic     s1_acc;
  word_t    s1_data;
  word_t    s1_haze;
  word_t    s1_hub;
  pf_mode_e s1_mode;
  word_t    s1_ct;
  word_t    s1_kt;
  word_t    s1_lt;
  logic     s1_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) s1_vld <= 1'b0;
    else       s1_vld <= in_vld;
  end

  always_ff @(posedge clk_i) begin
    if (in_vld) begin
      s1_acc   <= bus.laser_acc_flag_i;
      s1_data  <= bus.laser_data_i;
      s1_haze  <= bus.laser_haze_data_i;
      s1_hub   <= clamp_diff(bus.laser_data_i,
                             bus.laser_haze_data_i);
      s1_mode  <= pf_mode_e'(bus.filter_mode_i);
      s1_ct    <= bus.filter_curr_thre_i;
      s1_kt    <= bus.filter_cache_thre_i;
      s1_lt    <= bus.lp_filter_cache_thre_i;
      s1_ready <= in_ready;
    end
  end

  logic  c_acc;
  word_t c_haze;
  word_t c_data;
  word_t c_diff;
  word_t c_thre;

  assign c_acc  = rd_word[CW-1];
  assign c_haze = rd_word[2*DW-1:DW];
  assign c_data = rd_word[DW-1:0];
  assign c_diff = clamp_diff(c_data, c_haze);
  assign c_thre = c_acc ? s1_lt : s1_kt;

  logic     s2_vld;
  logic     s2_acc;
  word_t    s2_data;
  word_t    s2_haze;
  word_t    s2_hub;
  pf_mode_e s2_mode;
  logic     s2_ready;
  logic     s2_curr;
  logic     s2_cache;

  always_ff @(posedge clk_i) begin
    if (rst_i) s2_vld <= 1'b0;
    else       s2_vld <= s1_vld;
  end

  always_ff @(posedge clk_i) begin
    if (s1_vld) begin
      s2_acc   <= s1_acc;
      s2_data  <= s1_data;
      s2_haze  <= s1_haze;
      s2_hub   <= s1_hub;
      s2_mode  <= s1_mode;
      s2_ready <= s1_ready;
      s2_curr  <= s1_hub > s1_ct;
      s2_cache <= s1_ready && (c_diff > c_thre);
    end
  end

  logic          res_nxt;
  logic [HW-1:0] hit_nxt;

  always_comb begin
    res_nxt = 1'b0;
    hit_nxt = '0;
    unique case (1'b1)
      (s2_mode == MODE_CURR):  res_nxt = s2_curr;
      (s2_mode == MODE_CACHE): res_nxt = s2_cache;
      (s2_mode == MODE_AND):   res_nxt = s2_curr & s2_cache;
      (s2_mode == MODE_OR):    res_nxt = s2_curr | s2_cache;
    endcase
    if (res_nxt) begin
      if (&bus.filter_hit_cnt_o) hit_nxt = bus.filter_hit_cnt_o;
      else hit_nxt = bus.filter_hit_cnt_o + HW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.filter_vld_o          <= 1'b0;
      bus.filter_acc_flag_o     <= 1'b0;
      bus.filter_data_o         <= '0;
      bus.filter_haze_data_o    <= '0;
      bus.filter_haze_hub_o     <= '0;
      bus.filter_curr_result_o  <= 1'b0;
      bus.filter_cache_result_o <= 1'b0;
      bus.filter_result_o       <= 1'b0;
      bus.filter_hit_cnt_o      <= '0;
      bus.cache_ready_o         <= 1'b0;
    end else begin
      bus.filter_vld_o <= s2_vld;
      if (s2_vld) begin
        bus.filter_acc_flag_o     <= s2_acc;
        bus.filter_data_o         <= s2_data;
        bus.filter_haze_data_o    <= s2_haze;
        bus.filter_haze_hub_o     <= s2_hub;
        bus.filter_curr_result_o  <= s2_curr;
        bus.filter_cache_result_o <= s2_cache;
        bus.filter_result_o       <= res_nxt;
        bus.filter_hit_cnt_o      <= hit_nxt;
        bus.cache_ready_o         <= s2_ready;
      end
    end
  end

endmodule

// File: tb/tb_particle_filter_v3.sv
// Directed bench for particle_filter_v3 with a history-based model.
// Small cache (8 deep) and 2-bit hit counter exercise wrap and saturation.
module tb_particle_filter_v3;
  import particle_filter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int HW = 2;
  localparam int FILL_MAX = (1 << AW) - 1;
  localparam int HIT_MAX = (1 << HW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  particle_filter_v3_if #(
    .DATA_WIDTH (DW),
    .SPACING_AW (AW),
    .HIT_CNT_W  (HW)
  ) pf ();

  particle_filter_v3 #(
    .DATA_WIDTH (DW),
    .SPACING_AW (AW),
    .HIT_CNT_W  (HW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (pf)
  );

  typedef struct packed {
    int            due;
    bit            rst;
    logic          acc;
    logic [DW-1:0] data;
    logic [DW-1:0] haze;
    logic [DW-1:0] hub;
    logic          cr;
    logic          kr;
    logic          res;
    logic [HW-1:0] hit;
    logic          rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t last = '0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // model state: every sample since reset, plus current config
  int   h_data[$];
  int   h_haze[$];
  bit   h_acc[$];
  int   hit_m = 0;
  int   sp = 0, mode = 0, ct = 0, kt = 0, lt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cdiff(input int d, input int h);
    return (d > h) ? d - h : 0;
  endfunction

  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic drive_cfg();
    pf.light_spot_spacing_i   = AW'(sp);
    pf.filter_mode_i          = 2'(mode);
    pf.filter_curr_thre_i     = DW'(ct);
    pf.filter_cache_thre_i    = DW'(kt);
    pf.lp_filter_cache_thre_i = DW'(lt);
  endtask

  task automatic send(input bit acc, input int data, input int haze,
                      output exp_t r);
    int n, fill, j, thr;
    bit res;
    r = '0;
    n = h_data.size();
    fill = (n > FILL_MAX) ? FILL_MAX : n;
    r.acc  = acc;
    r.data = DW'(data);
    r.haze = DW'(haze);
    r.hub  = DW'(cdiff(data, haze));
    r.cr   = cdiff(data, haze) > ct;
    r.rdy  = (sp != 0) && (fill >= sp);
    r.kr   = 1'b0;
    if (r.rdy) begin
      j = n - sp;
      thr = h_acc[j] ? lt : kt;
      r.kr = cdiff(h_data[j], h_haze[j]) > thr;
    end
    case (mode)
      0: res = r.cr;
      1: res = r.kr;
      2: res = r.cr && r.kr;
      default: res = r.cr || r.kr;
    endcase
    r.res = res;
    hit_m = res ? ((hit_m == HIT_MAX) ? HIT_MAX : hit_m + 1) : 0;
    r.hit = HW'(hit_m);
    r.due = cyc + PF_LATENCY;
    h_data.push_back(data);
    h_haze.push_back(haze);
    h_acc.push_back(acc);
    exp_q.push_back(r);
    drive_cfg();
    pf.laser_vld_i       = 1'b1;
    pf.laser_acc_flag_i  = acc;
    pf.laser_data_i      = DW'(data);
    pf.laser_haze_data_i = DW'(haze);
    @(posedge clk);
    #1;
    pf.laser_vld_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pf.laser_vld_i       = 1'b0;
      pf.laser_data_i      = 16'hbeef;
      pf.laser_haze_data_i = 16'h0123;
      pf.laser_acc_flag_i  = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_rst(input int n, input bit with_vld);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      rst = 1'b1;
      pf.laser_vld_i = with_vld;
      pf.laser_data_i = 16'd900;
      while (exp_q.size() > 0 && exp_q[$].due > cyc)
        void'(exp_q.pop_back());
      e = '0;
      e.due = cyc + 1;
      e.rst = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    pf.laser_vld_i = 1'b0;
    h_data.delete();
    h_haze.delete();
    h_acc.delete();
    hit_m = 0;
  endtask

  always @(negedge clk) begin
    logic [55:0] want, got;
    logic ev;
    exp_t e;
    if (cyc >= 1) begin
      ev = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.rst) begin
          last = '0;
        end else begin
          last = e;
          ev = 1'b1;
        end
      end
      want = {ev, last.acc, last.data, last.haze, last.hub,
              last.cr, last.kr, last.res, last.hit, last.rdy};
      got  = {pf.filter_vld_o, pf.filter_acc_flag_o,
              pf.filter_data_o, pf.filter_haze_data_o,
              pf.filter_haze_hub_o, pf.filter_curr_result_o,
              pf.filter_cache_result_o, pf.filter_result_o,
              pf.filter_hit_cnt_o, pf.cache_ready_o};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, got, want);
      end
    end
  end

  exp_t r, rc[20];

  initial begin
    pf.laser_vld_i = 1'b0;
    pf.laser_acc_flag_i = 1'b0;
    pf.laser_data_i = '0;
    pf.laser_haze_data_i = '0;
    drive_cfg();
    do_rst(2, 1'b0);
    idle(3);

    // current path
    mode = 0; ct = 700; sp = 0;
    send(1'b0, 1000, 200, r);
    lit("curr_hub", int'(r.hub), 800);
    lit("curr_res", int'(r.res), 1);
    send(1'b0, 100, 300, r);
    lit("neg_hub", int'(r.hub), 0);
    lit("neg_res", int'(r.res), 0);
    idle(4);

    // cache path, spacing 4
    do_rst(1, 1'b0);
    mode = 1; sp = 4; kt = 250; lt = 250;
    for (int i = 0; i < 10; i++) send(1'b0, 100 * i, 0, rc[i]);
    for (int i = 0; i < 4; i++) lit("cache_early", int'(rc[i].kr), 0);
    lit("cache_s7", int'(rc[7].kr), 1);
    lit("cache_s6", int'(rc[6].kr), 0);
    idle(4);

    // lp threshold by cached acc flag
    do_rst(1, 1'b0);
    sp = 1; kt = 600; lt = 400;
    send(1'b1, 500, 0, r);
    send(1'b0, 0, 0, r);
    lit("lp_acc1", int'(r.kr), 1);
    send(1'b0, 500, 0, r);
    send(1'b0, 0, 0, r);
    lit("lp_acc0", int'(r.kr), 0);
    idle(4);

    // modes and saturating hit counter
    do_rst(1, 1'b0);
    sp = 2; ct = 100; kt = 100; lt = 100; mode = 0;
    send(1'b0, 0, 0, r);
    send(1'b0, 0, 0, r);
    mode = 2;
    send(1'b0, 500, 0, r);
    lit("and_res", int'(r.res), 0);
    mode = 3;
    send(1'b0, 500, 0, r);
    lit("or_res", int'(r.res), 1);
    for (int i = 0; i < 5; i++) send(1'b0, 500, 0, r);
    lit("hit_sat", int'(r.hit), 3);
    idle(2);
    mode = 0;
    send(1'b0, 0, 0, r);
    lit("hit_clr", int'(r.hit), 0);
    idle(3);

    // reset with samples in flight, and reset with a strobe
    mode = 3;
    send(1'b0, 700, 0, r);
    send(1'b0, 800, 0, r);
    do_rst(2, 1'b1);
    idle(5);

    // wrap: spacing 7 over an 8-deep cache
    sp = 7; mode = 1; kt = 100; lt = 40; ct = 90;
    for (int i = 0; i < 20; i++)
      send(1'(i % 5 == 0), (i * 37) % 256, (i % 3) * 20, rc[i]);
    lit("wrap_rdy6", int'(rc[6].rdy), 0);
    lit("wrap_rdy7", int'(rc[7].rdy), 1);

    // spacing changes without flush
    sp = 3; mode = 3;
    for (int i = 0; i < 4; i++) send(1'b0, 60 * i, 10, r);
    sp = 0;
    send(1'b0, 300, 0, r);
    lit("sp0_kr", int'(r.kr), 0);
    idle(6);

    lit("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
